// File: rtl/rv_fetch_pkg.sv
// ----------------------------------------------------------------------------
// rv_fetch_pkg
// Shared definitions for the instruction-fetch path:
//   - fetch_state_e   : sequencer states (IDLE, FETCH, VALID, DISCARD)
//   - RESET_VECTOR_DEF: default PC loaded at reset
//   - TRAP_VECTOR_DEF : default fetch target for a misaligned redirect
//   - is_misaligned() : word-alignment check on the two low address bits
// ----------------------------------------------------------------------------
package rv_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        VALID   = 2'd2,
        DISCARD = 2'd3
    } fetch_state_e;

    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h0000_0100;

    // Only the two low bits decide word alignment.
    function automatic logic is_misaligned(input logic [1:0] i_addr_lo);
        return (i_addr_lo != 2'b00);
    endfunction

endpackage

// File: rtl/pc_sequencer_adder.sv
// ----------------------------------------------------------------------------
// pc_sequencer_adder
// Sequential-PC incrementer: o_sum = i_a + 4, modulo 2^WIDTH.
// Ports:
//   i_a   in  WIDTH  current PC
//   o_sum out WIDTH  PC + 4 (wraps to 0 past the top of the address space)
// ----------------------------------------------------------------------------
module pc_sequencer_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    output logic [WIDTH-1:0] o_sum
);

    localparam logic [WIDTH-1:0] STEP = WIDTH'(4);

    assign o_sum = i_a + STEP;

endmodule

// File: rtl/pc_sequencer.sv
// ----------------------------------------------------------------------------
// pc_sequencer
// Instruction-fetch controller. Owns the PC, fetches one instruction at a
// time over a req/ack handshake, presents it to decode over valid/ready, and
// lets redirects (branch, jump, trap return) preempt sequential fetch.
// Misaligned redirect targets are replaced by TRAP_VECTOR and reported.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   imem_req/imem_addr      fetch request and word-aligned address
//   imem_ack/imem_rdata     memory accept, instruction data valid with ack
//   inst_valid/inst/inst_pc instruction presented to decode
//   inst_ready              decode consumes inst this cycle
//   redirect_valid/_pc      one-cycle redirect request and its target
//   trap_misaligned         one-cycle pulse on a misaligned redirect target
//   trap_epc                offending target, held until the next trap
// All outputs are registered.
// ----------------------------------------------------------------------------
module pc_sequencer
    import rv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter logic [31:0] TRAP_VECTOR  = TRAP_VECTOR_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        trap_misaligned,
    output logic [31:0] trap_epc
);

    fetch_state_e r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_pend;
    logic         r_req;
    logic         r_inst_valid;
    logic [31:0]  r_inst;
    logic [31:0]  r_inst_pc;
    logic         r_trap;
    logic [31:0]  r_trap_epc;

    fetch_state_e w_state_next;
    logic [31:0]  w_pc_next;
    logic [31:0]  w_pend_next;
    logic         w_req_next;
    logic         w_inst_valid_next;
    logic [31:0]  w_inst_next;
    logic [31:0]  w_inst_pc_next;
    logic         w_trap_next;
    logic [31:0]  w_trap_epc_next;

    logic [31:0]  w_pc_plus4;
    logic         w_misaligned;
    logic [31:0]  w_target;

    pc_sequencer_adder #(
        .WIDTH (32)
    ) u_adder (
        .i_a   (r_pc),
        .o_sum (w_pc_plus4)
    );

    // A misaligned target is never fetched; the trap vector is fetched instead.
    assign w_misaligned = is_misaligned(redirect_pc[1:0]);
    assign w_target     = w_misaligned ? TRAP_VECTOR : redirect_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_pc         <= RESET_VECTOR;
            r_pend       <= RESET_VECTOR;
            r_req        <= 1'b0;
            r_inst_valid <= 1'b0;
            r_inst       <= 32'h0;
            r_inst_pc    <= 32'h0;
            r_trap       <= 1'b0;
            r_trap_epc   <= 32'h0;
        end else begin
            r_state      <= w_state_next;
            r_pc         <= w_pc_next;
            r_pend       <= w_pend_next;
            r_req        <= w_req_next;
            r_inst_valid <= w_inst_valid_next;
            r_inst       <= w_inst_next;
            r_inst_pc    <= w_inst_pc_next;
            r_trap       <= w_trap_next;
            r_trap_epc   <= w_trap_epc_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_pc_next         = r_pc;
        w_pend_next       = r_pend;
        w_inst_valid_next = r_inst_valid;
        w_inst_next       = r_inst;
        w_inst_pc_next    = r_inst_pc;
        w_trap_next       = 1'b0;
        w_trap_epc_next   = r_trap_epc;

        if (redirect_valid && w_misaligned) begin
            w_trap_next     = 1'b1;
            w_trap_epc_next = redirect_pc;
        end

        case (r_state)
            IDLE: begin
                if (redirect_valid) begin
                    w_pc_next = w_target;
                end
                w_state_next = FETCH;
            end

            FETCH: begin
                if (redirect_valid) begin
                    if (imem_ack) begin
                        // Response arrives with the redirect: drop it and
                        // request the new target straight away.
                        w_pc_next    = w_target;
                        w_state_next = FETCH;
                    end else begin
                        // Request must stay stable until ack, so park the
                        // target and leave imem_addr (r_pc) untouched.
                        w_pend_next  = w_target;
                        w_state_next = DISCARD;
                    end
                end else if (imem_ack) begin
                    w_inst_valid_next = 1'b1;
                    w_inst_next       = imem_rdata;
                    w_inst_pc_next    = r_pc;
                    w_state_next      = VALID;
                end
            end

            VALID: begin
                if (redirect_valid) begin
                    w_inst_valid_next = 1'b0;
                    w_pc_next         = w_target;
                    w_state_next      = FETCH;
                end else if (inst_ready) begin
                    w_inst_valid_next = 1'b0;
                    w_pc_next         = w_pc_plus4;
                    w_state_next      = FETCH;
                end
            end

            DISCARD: begin
                if (redirect_valid) begin
                    w_pend_next = w_target;
                end
                if (imem_ack) begin
                    // A redirect in the ack cycle supersedes the parked target.
                    w_pc_next    = redirect_valid ? w_target : r_pend;
                    w_state_next = FETCH;
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase

        w_req_next = (w_state_next == FETCH) || (w_state_next == DISCARD);
    end

    assign imem_req        = r_req;
    assign imem_addr       = r_pc;
    assign inst_valid      = r_inst_valid;
    assign inst            = r_inst;
    assign inst_pc         = r_inst_pc;
    assign trap_misaligned = r_trap;
    assign trap_epc        = r_trap_epc;

endmodule

// File: tb/tb_pc_sequencer.sv
// ----------------------------------------------------------------------------
// tb_pc_sequencer
// Directed bench for pc_sequencer. Inputs change and outputs are sampled 1 ns
// after each rising edge. Memory data is a fixed function of the address.
// ----------------------------------------------------------------------------
module tb_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        trap_misaligned;
    logic [31:0] trap_epc;

    int n_checks;
    int n_fail;

    pc_sequencer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .inst_valid      (inst_valid),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .inst_ready      (inst_ready),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .trap_misaligned (trap_misaligned),
        .trap_epc        (trap_epc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return addr ^ 32'h1357_9BDF;
    endfunction

    task automatic check_value(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Zero-wait fetch of an expected address, then a one-cycle handshake.
    task automatic fetch_and_take(input logic [31:0] exp_addr);
        check_value("req_hi", 32'(imem_req), 32'h1);
        check_value("req_addr", imem_addr, exp_addr);
        imem_ack   = 1'b1;
        imem_rdata = mem_word(exp_addr);
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        check_value("valid_hi", 32'(inst_valid), 32'h1);
        check_value("inst_pc", inst_pc, exp_addr);
        check_value("inst", inst, mem_word(exp_addr));
        check_value("req_lo_in_valid", 32'(imem_req), 32'h0);
        $display("fetch addr=%h inst_pc=%h inst=%h", exp_addr, inst_pc, inst);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        check_value("valid_lo_after_take", 32'(inst_valid), 32'h0);
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        rst_n          = 1'b0;
        imem_ack       = 1'b0;
        imem_rdata     = 32'hDEAD_BEEF;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        // Reset values
        tick();
        tick();
        check_value("rst_req", 32'(imem_req), 32'h0);
        check_value("rst_addr", imem_addr, 32'h0);
        check_value("rst_valid", 32'(inst_valid), 32'h0);
        check_value("rst_inst", inst, 32'h0);
        check_value("rst_inst_pc", inst_pc, 32'h0);
        check_value("rst_trap", 32'(trap_misaligned), 32'h0);
        check_value("rst_epc", trap_epc, 32'h0);
        $display("reset released");
        rst_n = 1'b1;
        tick();

        // Sequential zero-wait fetches: 0x0, 0x4, 0x8
        for (int k = 0; k < 3; k++) begin
            fetch_and_take(32'(4 * k));
        end

        // 3-cycle ack latency at 0xC: request held stable, valid 1 cycle after ack
        for (int c = 0; c < 2; c++) begin
            check_value("slow_req", 32'(imem_req), 32'h1);
            check_value("slow_addr", imem_addr, 32'h0000_000C);
            tick();
            check_value("slow_no_valid", 32'(inst_valid), 32'h0);
        end
        check_value("slow_req_ackcyc", 32'(imem_req), 32'h1);
        check_value("slow_addr_ackcyc", imem_addr, 32'h0000_000C);
        imem_ack   = 1'b1;
        imem_rdata = mem_word(32'h0000_000C);
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        check_value("slow_valid", 32'(inst_valid), 32'h1);
        check_value("slow_inst_pc", inst_pc, 32'h0000_000C);
        $display("slow fetch addr=0000000c inst=%h", inst);

        // Decode stalls 5 cycles: instruction held, no new request
        for (int c = 0; c < 5; c++) begin
            tick();
            check_value("stall_valid", 32'(inst_valid), 32'h1);
            check_value("stall_inst", inst, mem_word(32'h0000_000C));
            check_value("stall_inst_pc", inst_pc, 32'h0000_000C);
            check_value("stall_req", 32'(imem_req), 32'h0);
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        check_value("after_stall_addr", imem_addr, 32'h0000_0010);
        check_value("after_stall_req", 32'(imem_req), 32'h1);

        // Redirect to 0x200 while 0x10 is outstanding, ack 2 cycles later
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        tick();
        redirect_valid = 1'b0;
        check_value("disc_req", 32'(imem_req), 32'h1);
        check_value("disc_addr_hold", imem_addr, 32'h0000_0010);
        tick();
        check_value("disc_addr_hold2", imem_addr, 32'h0000_0010);
        imem_ack   = 1'b1;
        imem_rdata = mem_word(32'h0000_0010);
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        check_value("disc_dropped", 32'(inst_valid), 32'h0);
        $display("redirect 00000200 taken after discard");
        fetch_and_take(32'h0000_0200);

        // Misaligned redirect 0x203 arriving with an ack in FETCH
        check_value("pre_trap_addr", imem_addr, 32'h0000_0204);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        imem_ack       = 1'b1;
        imem_rdata     = mem_word(32'h0000_0204);
        tick();
        redirect_valid = 1'b0;
        imem_ack       = 1'b0;
        imem_rdata     = 32'hDEAD_BEEF;
        check_value("trap_pulse", 32'(trap_misaligned), 32'h1);
        check_value("trap_epc", trap_epc, 32'h0000_0203);
        check_value("trap_addr", imem_addr, 32'h0000_0100);
        check_value("trap_ack_dropped", 32'(inst_valid), 32'h0);
        tick();
        check_value("trap_pulse_end", 32'(trap_misaligned), 32'h0);
        check_value("trap_epc_held", trap_epc, 32'h0000_0203);
        $display("misaligned redirect 00000203 -> 00000100");

        // Fetch 0x100, redirect from VALID to 0xFFFFFFFC, then wrap to 0
        imem_ack   = 1'b1;
        imem_rdata = mem_word(32'h0000_0100);
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        check_value("vec_inst_pc", inst_pc, 32'h0000_0100);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        check_value("redir_valid_drop", 32'(inst_valid), 32'h0);
        check_value("redir_top_trap", 32'(trap_misaligned), 32'h0);
        fetch_and_take(32'hFFFF_FFFC);
        check_value("wrap_addr", imem_addr, 32'h0000_0000);

        // Reset asserted during FETCH with an ack pending
        imem_ack   = 1'b1;
        imem_rdata = mem_word(32'h0000_0000);
        rst_n      = 1'b0;
        #1;
        check_value("midrst_req", 32'(imem_req), 32'h0);
        check_value("midrst_addr", imem_addr, 32'h0000_0000);
        tick();
        check_value("midrst_valid", 32'(inst_valid), 32'h0);
        check_value("midrst_epc", trap_epc, 32'h0);
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        rst_n      = 1'b1;
        tick();
        check_value("postrst_req", 32'(imem_req), 32'h1);
        check_value("postrst_addr", imem_addr, 32'h0000_0000);
        $display("reset during fetch recovered");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
